draw_shield: RTL and testbench

DRAW_SHIELD -- requirements
Module: draw_shield

---
 rtl/draw_shield_if.sv | 18 +
 rtl/draw_shield.sv | 107 ++++++++++
 tb/tb_draw_shield.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_shield_if.sv
// VGA timing bundle: beam position, sync and blanking strobes, and the pixel colour.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

    modport out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
endinterface

// File: rtl/draw_shield.sv
// Overlays a 64x64 shield sprite from an external synchronous ROM onto a VGA stream.
// The sprite hides on pickup until start_game drops; the pipeline latency is 2 clocks.
module draw_shield #(
    parameter int unsigned XPOS = 800,
    parameter int unsigned YPOS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_game,
    input  logic        en,
    input  logic        was_shield_picked_up,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] pixel_addr,
    vga_if.in           in,
    vga_if.out          out
);

    localparam logic [11:0] XLO  = 12'(XPOS);
    localparam logic [11:0] XHI  = 12'(XPOS + 63);
    localparam logic [11:0] YLO  = 12'(YPOS);
    localparam logic [11:0] YHI  = 12'(YPOS + 63);
    localparam logic [5:0]  XOFF = 6'(XPOS);
    localparam logic [5:0]  YOFF = 6'(YPOS);

    logic        in_box;
    logic [5:0]  dx;
    logic [5:0]  dy;

    logic [10:0] vcount_s1;
    logic [10:0] hcount_s1;
    logic        vsync_s1;
    logic        hsync_s1;
    logic        vblnk_s1;
    logic        hblnk_s1;
    logic [11:0] rgb_s1;
    logic        box_s1;
    logic        shown;
    logic        draw;

    // Compares are widened by one bit so a box near the right edge cannot wrap.
    always_comb begin
        in_box = ({1'b0, in.hcount} >= XLO) && ({1'b0, in.hcount} <= XHI) &&
                 ({1'b0, in.vcount} >= YLO) && ({1'b0, in.vcount} <= YHI);
        dx = in.hcount[5:0] - XOFF;
        dy = in.vcount[5:0] - YOFF;
        pixel_addr = in_box ? {dy, dx} : 12'h000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcount_s1 <= '0;
            hcount_s1 <= '0;
            vsync_s1  <= 1'b0;
            hsync_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            rgb_s1    <= '0;
            box_s1    <= 1'b0;
        end else begin
            vcount_s1 <= in.vcount;
            hcount_s1 <= in.hcount;
            vsync_s1  <= in.vsync;
            hsync_s1  <= in.hsync;
            vblnk_s1  <= in.vblnk;
            hblnk_s1  <= in.hblnk;
            rgb_s1    <= in.rgb;
            box_s1    <= in_box;
        end
    end

    // A stopped game re-arms the sprite and overrides a simultaneous pickup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shown <= 1'b1;
        end else if (!start_game) begin
            shown <= 1'b1;
        end else if (was_shield_picked_up) begin
            shown <= 1'b0;
        end
    end

    always_comb begin
        draw = box_s1 && !hblnk_s1 && !vblnk_s1 && start_game && en && shown &&
               (rgb_pixel != 12'h000);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out.vcount <= '0;
            out.hcount <= '0;
            out.vsync  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= vcount_s1;
            out.hcount <= hcount_s1;
            out.vsync  <= vsync_s1;
            out.hsync  <= hsync_s1;
            out.vblnk  <= vblnk_s1;
            out.hblnk  <= hblnk_s1;
            out.rgb    <= draw ? rgb_pixel : rgb_s1;
        end
    end

endmodule

// File: tb/tb_draw_shield.sv
// Directed bench for draw_shield: address mapping, sprite overlay, transparency, blanking,
// pickup/re-arm, enables and asynchronous reset.
module tb_draw_shield;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_game = 1'b0;
    logic        en = 1'b0;
    logic        pick = 1'b0;
    logic [11:0] rgb_pixel;
    logic [11:0] pixel_addr;
    int          total = 0;
    int          bad = 0;

    vga_if vin ();
    vga_if vout ();

    draw_shield #(.XPOS(800), .YPOS(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_game           (start_game),
        .en                   (en),
        .was_shield_picked_up (pick),
        .rgb_pixel            (rgb_pixel),
        .pixel_addr           (pixel_addr),
        .in                   (vin),
        .out                  (vout)
    );

    always #5 clk = ~clk;

    // Known image: word 0 (and 0x3C7) is transparent, the rest is addr ^ 0x3C7.
    function automatic logic [11:0] rom_f(input logic [11:0] a);
        return (a == 12'h000) ? 12'h000 : (a ^ 12'h3C7);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rgb_pixel <= 12'h000;
        else      rgb_pixel <= rom_f(pixel_addr);
    end

    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [11:0] bg,
                                            input logic blank, input logic ok);
        logic [11:0] r;
        if (h >= 800 && h <= 863 && v >= 16 && v <= 79 && !blank && ok) begin
            r = rom_f(12'((v - 16) * 64 + (h - 800)));
            if (r != 12'h000) return r;
        end
        return bg;
    endfunction

    function automatic logic [11:0] bg_of(input int h, input int v);
        return 12'(h * 5 + v * 64) ^ 12'h800;
    endfunction

    task automatic drive_pix(input int h, input int v, input logic [11:0] rgb,
                             input logic hb, input logic vb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.rgb    = rgb;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = ((h % 7) == 3);
        vin.vsync  = ((v % 5) == 1);
    endtask

    task automatic test_reset();
        drive_pix(801, 16, 12'hFFF, 1'b1, 1'b1);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (vout.rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got %h want 000", vout.rgb); end
        total++; if (vout.hcount !== 11'd0) begin bad++; $display("FAIL reset_hcount got %0d want 0", vout.hcount); end
        total++; if (vout.vcount !== 11'd0) begin bad++; $display("FAIL reset_vcount got %0d want 0", vout.vcount); end
        total++; if (vout.hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync got %b want 0", vout.hsync); end
        total++; if (vout.vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync got %b want 0", vout.vsync); end
        total++; if (vout.hblnk !== 1'b0 || vout.vblnk !== 1'b0) begin
            bad++; $display("FAIL reset_blnk got %b%b want 00", vout.hblnk, vout.vblnk);
        end
        start_game = 1'b1;
        en = 1'b1;
        drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
        rst = 1'b1;
    endtask

    task automatic test_addr();
        drive_pix(800, 16, 12'h123, 1'b0, 1'b0);
        #1;
        total++; if (pixel_addr !== 12'd0) begin bad++; $display("FAIL addr_800_16 got %0d want 0", pixel_addr); end
        drive_pix(863, 79, 12'h123, 1'b0, 1'b0);
        #1;
        total++; if (pixel_addr !== 12'd4095) begin bad++; $display("FAIL addr_863_79 got %0d want 4095", pixel_addr); end
        drive_pix(801, 17, 12'h123, 1'b0, 1'b0);
        #1;
        total++; if (pixel_addr !== 12'd65) begin bad++; $display("FAIL addr_801_17 got %0d want 65", pixel_addr); end
        drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_draw_rows();
        int rows[5] = '{15, 16, 47, 79, 80};
        int starts[2] = '{795, 858};
        int eh[16];
        int ev[16];
        logic [11:0] er[16];
        foreach (rows[r]) begin
            foreach (starts[s]) begin
                for (int i = 0; i < 13; i++) begin
                    @(posedge clk);
                    #1;
                    if (i >= 2) begin
                        total++;
                        if (vout.rgb !== er[i-2]) begin
                            bad++;
                            $display("FAIL draw_rgb (%0d,%0d) got %h want %h", eh[i-2], ev[i-2], vout.rgb, er[i-2]);
                        end
                        total++;
                        if (vout.hcount !== 11'(eh[i-2]) || vout.vcount !== 11'(ev[i-2])) begin
                            bad++;
                            $display("FAIL draw_pos got (%0d,%0d) want (%0d,%0d)", vout.hcount, vout.vcount, eh[i-2], ev[i-2]);
                        end
                        total++;
                        if (vout.hsync !== ((eh[i-2] % 7) == 3) || vout.vsync !== ((ev[i-2] % 5) == 1)) begin
                            bad++;
                            $display("FAIL draw_sync (%0d,%0d) got hs=%b vs=%b", eh[i-2], ev[i-2], vout.hsync, vout.vsync);
                        end
                    end
                    if (i < 11) begin
                        eh[i] = starts[s] + i;
                        ev[i] = rows[r];
                        er[i] = exp_rgb(eh[i], ev[i], bg_of(eh[i], ev[i]), 1'b0, 1'b1);
                        drive_pix(eh[i], ev[i], bg_of(eh[i], ev[i]), 1'b0, 1'b0);
                    end else begin
                        drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
                    end
                end
            end
        end
    endtask

    task automatic test_transparent();
        logic [11:0] er[2] = '{12'h0F0, 12'h3C6};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                total++;
                if (vout.rgb !== er[i-2]) begin
                    bad++;
                    $display("FAIL transparent h=%0d got %h want %h", 800 + i - 2, vout.rgb, er[i-2]);
                end
            end
            if (i < 2) drive_pix(800 + i, 16, 12'h0F0, 1'b0, 1'b0);
            else       drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
        end
    endtask

    task automatic test_blank();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                total++;
                if (vout.rgb !== bg_of(808 + i, 20) || vout.hblnk !== (i < 4) || vout.vblnk !== (i >= 4)) begin
                    bad++;
                    $display("FAIL blank h=%0d got rgb=%h hb=%b vb=%b want rgb=%h", 808 + i, vout.rgb,
                             vout.hblnk, vout.vblnk, bg_of(808 + i, 20));
                end
            end
            if (i < 4) drive_pix(810 + i, 20, bg_of(810 + i, 20), i < 2, i >= 2);
            else       drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
        end
    endtask

    task automatic test_pickup();
        int h;
        logic [11:0] er[40];
        // pickup pulse at i=10: pixels 0..9 still drawn, 10 onward hidden
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) begin
                total++;
                if (vout.rgb !== er[i-2]) begin
                    bad++;
                    $display("FAIL pickup h=%0d got %h want %h", 800 + i - 2, vout.rgb, er[i-2]);
                end
            end
            pick = (i == 10);
            if (i < 30) begin
                h = 800 + i;
                er[i] = exp_rgb(h, 20, bg_of(h, 20), 1'b0, i < 10);
                drive_pix(h, 20, bg_of(h, 20), 1'b0, 1'b0);
            end else begin
                drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
            end
        end
        // still hidden on a later line, re-armed by start_game low, then pickup vs stop priority
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 1 || pass == 2) begin
                start_game = 1'b0;
                pick = (pass == 2);
                @(posedge clk);
                #1;
                start_game = 1'b1;
                pick = 1'b0;
            end
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (i >= 2) begin
                    total++;
                    if (vout.rgb !== er[i-2]) begin
                        bad++;
                        $display("FAIL rearm pass=%0d h=%0d got %h want %h", pass, 830 + i - 2, vout.rgb, er[i-2]);
                    end
                end
                if (i < 8) begin
                    h = 830 + i;
                    er[i] = exp_rgb(h, 21, bg_of(h, 21), 1'b0, pass != 0);
                    drive_pix(h, 21, bg_of(h, 21), 1'b0, 1'b0);
                end else begin
                    drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
                end
            end
        end
    endtask

    task automatic test_disable();
        for (int mode = 0; mode < 2; mode++) begin
            en = (mode != 0);
            start_game = (mode == 0);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (i >= 2) begin
                    total++;
                    if (vout.rgb !== bg_of(798 + i - 2, 30)) begin
                        bad++;
                        $display("FAIL disable mode=%0d h=%0d got %h want %h", mode, 798 + i - 2, vout.rgb,
                                 bg_of(798 + i - 2, 30));
                    end
                end
                if (i < 10) drive_pix(798 + i, 30, bg_of(798 + i, 30), 1'b0, 1'b0);
                else        drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
            end
        end
        en = 1'b1;
        start_game = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive_pix(805 + i, 40, bg_of(805 + i, 40), 1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (vout.rgb !== 12'h000 || vout.hcount !== 11'd0 || vout.vcount !== 11'd0) begin
            bad++;
            $display("FAIL async_reset got rgb=%h h=%0d v=%0d want zeros", vout.rgb, vout.hcount, vout.vcount);
        end
        total++; if (vout.hsync !== 1'b0 || vout.vsync !== 1'b0) begin
            bad++; $display("FAIL async_reset_sync got hs=%b vs=%b want 00", vout.hsync, vout.vsync);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_pix(810, 40, bg_of(810, 40), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        total++; if (vout.hcount !== 11'd0 || vout.rgb !== 12'h000) begin
            bad++; $display("FAIL release_1clk got h=%0d rgb=%h want 0 000", vout.hcount, vout.rgb);
        end
        drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        total++; if (vout.hcount !== 11'd810 || vout.vcount !== 11'd40) begin
            bad++; $display("FAIL release_2clk got (%0d,%0d) want (810,40)", vout.hcount, vout.vcount);
        end
        total++; if (vout.rgb !== exp_rgb(810, 40, bg_of(810, 40), 1'b0, 1'b1)) begin
            bad++;
            $display("FAIL release_rgb got %h want %h", vout.rgb, exp_rgb(810, 40, bg_of(810, 40), 1'b0, 1'b1));
        end
    endtask

    initial begin
        drive_pix(0, 0, 12'h000, 1'b1, 1'b1);
        test_reset();
        test_addr();
        test_draw_rows();
        test_transparent();
        test_blank();
        test_pickup();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
